// File: rtl/vx_pe_credit_sched.sv
// vx_pe_credit_sched: dispatch controller in front of the PE request switch.
// Gates the execute handshake on per-PE issue credits and keeps every warp on
// a single PE while it has ops in flight, so commits stay in order.
// Optional feature macro: PE_SCHED_PERF_EN (credit/order stall counters).
module vx_pe_credit_sched #(
  parameter int PE_COUNT    = 2,
  parameter int NUM_WARPS   = 4,
  parameter int PE_CREDITS  = 4,
  parameter int PE_SEL_BITS = $clog2(PE_COUNT),
  parameter int CNT_W       = $clog2(PE_CREDITS + 1),
  parameter int WCNT_W      = $clog2(PE_COUNT * PE_CREDITS + 1),
  parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int SEL_W       = (PE_SEL_BITS > 0) ? PE_SEL_BITS : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [SEL_W-1:0]             req_pe,
  input  logic [NW_WIDTH-1:0]          req_wid,
  output logic                         req_ready,
  output logic                         disp_valid,
  output logic [SEL_W-1:0]             disp_sel,
  input  logic                         disp_ready,
  input  logic [PE_COUNT-1:0]          cmt_fire,
  input  logic [PE_COUNT*NW_WIDTH-1:0] cmt_wid,
  output logic [PE_COUNT*CNT_W-1:0]    pe_pending,
  output logic                         busy,
  output logic [31:0]                  perf_crd_stall,
  output logic [31:0]                  perf_ord_stall
);

  logic [CNT_W-1:0]  cnt_q  [PE_COUNT];
  logic [CNT_W-1:0]  cnt_d  [PE_COUNT];
  logic [WCNT_W-1:0] wcnt_q [NUM_WARPS];
  logic [WCNT_W-1:0] wcnt_d [NUM_WARPS];
  logic [SEL_W-1:0]  last_q [NUM_WARPS];
  logic [SEL_W-1:0]  last_d [NUM_WARPS];
  logic              seen_cmt_q, seen_cmt_d;

  logic              pe_in_range;
  logic              wid_in_range;
  logic [CNT_W-1:0]  sel_cnt;
  logic [WCNT_W-1:0] sel_wcnt;
  logic [SEL_W-1:0]  sel_last;
  logic              crd_ok, ord_ok, go, fire;

  logic [PE_COUNT-1:0] whit;
  logic                inc, dec;
  logic                underflow, multi_hit;

  // Look up the counters addressed by the current request
  always_comb begin
    pe_in_range  = 1'b0;
    wid_in_range = 1'b0;
    sel_cnt      = '0;
    sel_wcnt     = '0;
    sel_last     = '0;
    for (int unsigned p = 0; p < PE_COUNT; p++) begin
      if (req_pe == SEL_W'(p)) begin
        pe_in_range = 1'b1;
        sel_cnt     = cnt_q[p];
      end
    end
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (req_wid == NW_WIDTH'(w)) begin
        wid_in_range = 1'b1;
        sel_wcnt     = wcnt_q[w];
        sel_last     = last_q[w];
      end
    end
  end

  // Zero-latency handshake; an out-of-range PE is treated as credit-blocked
  always_comb begin
    crd_ok     = pe_in_range && (sel_cnt < CNT_W'(PE_CREDITS));
    ord_ok     = (sel_wcnt == '0) || (sel_last == req_pe);
    go         = crd_ok && ord_ok && reset;
    disp_valid = req_valid && go;
    req_ready  = disp_ready && go;
    disp_sel   = req_pe;
    fire       = req_valid && req_ready;
  end

  // Next-state for credit and ordering counters; commits at zero saturate
  always_comb begin
    underflow  = 1'b0;
    multi_hit  = 1'b0;
    whit       = '0;
    inc        = 1'b0;
    dec        = 1'b0;
    seen_cmt_d = seen_cmt_q || (|cmt_fire);
    for (int unsigned p = 0; p < PE_COUNT; p++) begin
      inc = fire && (req_pe == SEL_W'(p));
      dec = cmt_fire[p] && (cnt_q[p] != '0);
      if (cmt_fire[p] && (cnt_q[p] == '0))
        underflow = 1'b1;
      cnt_d[p] = cnt_q[p] + CNT_W'(inc) - CNT_W'(dec);
    end
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      for (int unsigned p = 0; p < PE_COUNT; p++)
        whit[p] = cmt_fire[p] && (cmt_wid[p*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w));
      if ($countones(whit) > 1)
        multi_hit = 1'b1;
      if ((|whit) && (wcnt_q[w] == '0))
        underflow = 1'b1;
      inc       = fire && (req_wid == NW_WIDTH'(w));
      dec       = (|whit) && (wcnt_q[w] != '0);
      wcnt_d[w] = wcnt_q[w] + WCNT_W'(inc) - WCNT_W'(dec);
      last_d[w] = inc ? req_pe : last_q[w];
    end
  end

  // Tracking state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < PE_COUNT; p++)
        cnt_q[p] <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        wcnt_q[w] <= '0;
        last_q[w] <= '0;
      end
      seen_cmt_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < PE_COUNT; p++)
        cnt_q[p] <= cnt_d[p];
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        wcnt_q[w] <= wcnt_d[w];
        last_q[w] <= last_d[w];
      end
      seen_cmt_q <= seen_cmt_d;
    end
  end

  // Status outputs
  always_comb begin
    busy       = 1'b0;
    pe_pending = '0;
    for (int unsigned p = 0; p < PE_COUNT; p++) begin
      pe_pending[p*CNT_W +: CNT_W] = cnt_q[p];
      if (cnt_q[p] != '0)
        busy = 1'b1;
    end
  end

`ifdef PE_SCHED_PERF_EN
  logic [31:0] crd_stall_q, crd_stall_d;
  logic [31:0] ord_stall_q, ord_stall_d;

  // Stall counters; order stalls only count when credits were available
  always_comb begin
    crd_stall_d = crd_stall_q;
    ord_stall_d = ord_stall_q;
    if (req_valid && !crd_ok)
      crd_stall_d = crd_stall_q + 32'd1;
    if (req_valid && crd_ok && !ord_ok)
      ord_stall_d = ord_stall_q + 32'd1;
  end

  // Stall counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crd_stall_q <= '0;
      ord_stall_q <= '0;
    end else begin
      crd_stall_q <= crd_stall_d;
      ord_stall_q <= ord_stall_d;
    end
  end

  assign perf_crd_stall = crd_stall_q;
  assign perf_ord_stall = ord_stall_q;
`else
  assign perf_crd_stall = '0;
  assign perf_ord_stall = '0;
`endif

  // Illegal traffic checks; the first commit after reset may be a stale one
  a_pe_range:  assert property (@(posedge clk) disable iff (!reset)
                                !(req_valid && !pe_in_range));
  a_wid_range: assert property (@(posedge clk) disable iff (!reset)
                                !(req_valid && !wid_in_range));
  a_multi_cmt: assert property (@(posedge clk) disable iff (!reset) !multi_hit);
  a_underflow: assert property (@(posedge clk) disable iff (!reset)
                                !(underflow && seen_cmt_q));

endmodule

// File: tb/tb_vx_pe_credit_sched.sv
// Self-checking bench for vx_pe_credit_sched (PE_COUNT=2, NUM_WARPS=4, PE_CREDITS=4).
module tb_vx_pe_credit_sched;

  localparam int PE_COUNT   = 2;
  localparam int NUM_WARPS  = 4;
  localparam int PE_CREDITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [0:0]  req_pe;
  logic [1:0]  req_wid;
  logic        req_ready;
  logic        disp_valid;
  logic [0:0]  disp_sel;
  logic        disp_ready;
  logic [1:0]  cmt_fire;
  logic [3:0]  cmt_wid;
  logic [5:0]  pe_pending;
  logic        busy;
  logic [31:0] perf_crd_stall;
  logic [31:0] perf_ord_stall;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [0:0] exp_q [$];

  typedef struct packed {
    logic       v;
    logic [0:0] pe;
    logic [1:0] wid;
    logic       dr;
    logic [1:0] cf;
    logic [3:0] cw;
    logic       xdv;
    logic       xrr;
    logic [2:0] xp0;
    logic [2:0] xp1;
    logic       xbusy;
  } vec_t;

  vx_pe_credit_sched #(
    .PE_COUNT  (PE_COUNT),
    .NUM_WARPS (NUM_WARPS),
    .PE_CREDITS(PE_CREDITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_pe        (req_pe),
    .req_wid       (req_wid),
    .req_ready     (req_ready),
    .disp_valid    (disp_valid),
    .disp_sel      (disp_sel),
    .disp_ready    (disp_ready),
    .cmt_fire      (cmt_fire),
    .cmt_wid       (cmt_wid),
    .pe_pending    (pe_pending),
    .busy          (busy),
    .perf_crd_stall(perf_crd_stall),
    .perf_ord_stall(perf_ord_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic pe, input logic [1:0] wid,
                              input logic dr, input logic [1:0] cf, input logic [3:0] cw,
                              input logic xdv, input logic xrr, input logic [2:0] xp0,
                              input logic [2:0] xp1, input logic xbusy);
    vec_t r;
    r.v = v; r.pe = pe; r.wid = wid; r.dr = dr; r.cf = cf; r.cw = cw;
    r.xdv = xdv; r.xrr = xrr; r.xp0 = xp0; r.xp1 = xp1; r.xbusy = xbusy;
    return r;
  endfunction

  // Called just after a rising edge: drive, settle, compare, advance one cycle.
  task automatic apply(input vec_t t, input string tag);
    logic [0:0] e;
    req_valid  = t.v;
    req_pe     = t.pe;
    req_wid    = t.wid;
    disp_ready = t.dr;
    cmt_fire   = t.cf;
    cmt_wid    = t.cw;
    if (t.xdv && t.dr) exp_q.push_back(t.pe);
    #2;
    chk({tag, ".disp_valid"}, 32'(disp_valid), 32'(t.xdv));
    chk({tag, ".req_ready"},  32'(req_ready),  32'(t.xrr));
    chk({tag, ".disp_sel"},   32'(disp_sel),   32'(t.pe));
    chk({tag, ".pend0"},      32'(pe_pending[2:0]), 32'(t.xp0));
    chk({tag, ".pend1"},      32'(pe_pending[5:3]), 32'(t.xp1));
    chk({tag, ".busy"},       32'(busy),       32'(t.xbusy));
    if (disp_valid && disp_ready) begin
      if (exp_q.size() == 0) chk({tag, ".sb_extra"}, 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk({tag, ".sb_sel"}, 32'(disp_sel), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [$];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 1, 2'b00, 4'h0, 0, 0, 0, 0, 0);

    // credit exhaustion on PE0, then drain
    tbl.push_back(mk(0,0,0,1,2'b01,4'h0, 0,1,0,0,0));  // first commit after reset: saturates
    tbl.push_back(mk(1,0,0,1,2'b00,4'h0, 1,1,0,0,0));
    tbl.push_back(mk(1,0,1,1,2'b00,4'h0, 1,1,1,0,1));
    tbl.push_back(mk(1,0,2,1,2'b00,4'h0, 1,1,2,0,1));
    tbl.push_back(mk(1,0,3,1,2'b00,4'h0, 1,1,3,0,1));
    tbl.push_back(mk(1,0,0,1,2'b00,4'h0, 0,0,4,0,1));  // full
    tbl.push_back(mk(1,0,0,1,2'b01,4'h1, 0,0,4,0,1));  // freed credit not usable yet
    tbl.push_back(mk(1,0,0,1,2'b00,4'h0, 1,1,3,0,1));  // 5th op fires
    tbl.push_back(mk(0,0,0,1,2'b01,4'h0, 0,0,4,0,1));
    tbl.push_back(mk(0,0,0,1,2'b01,4'h2, 0,1,3,0,1));
    tbl.push_back(mk(0,0,0,1,2'b01,4'h3, 0,1,2,0,1));
    tbl.push_back(mk(0,0,0,1,2'b01,4'h0, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0,1,2'b00,4'h0, 0,1,0,0,0));
    // per-warp ordering
    tbl.push_back(mk(1,0,2,1,2'b00,4'h0, 1,1,0,0,0));
    tbl.push_back(mk(1,1,2,1,2'b00,4'h0, 0,0,1,0,1));  // warp 2 pinned to PE0
    tbl.push_back(mk(1,1,3,1,2'b00,4'h0, 1,1,1,0,1));  // warp 3 proceeds
    tbl.push_back(mk(1,1,2,1,2'b01,4'h2, 0,0,1,1,1));  // commit frees order next cycle
    tbl.push_back(mk(1,1,2,1,2'b00,4'h0, 1,1,0,1,1));
    tbl.push_back(mk(1,1,2,1,2'b00,4'h0, 1,1,0,2,1));
    tbl.push_back(mk(1,1,3,1,2'b00,4'h0, 1,1,0,3,1));
    // PE1 full, commit on PE1 with PE0 fire
    tbl.push_back(mk(1,1,2,1,2'b00,4'h0, 0,0,0,4,1));
    tbl.push_back(mk(1,0,0,1,2'b10,4'h8, 1,1,0,4,1));
    tbl.push_back(mk(0,0,0,1,2'b00,4'h0, 0,1,1,3,1));
    tbl.push_back(mk(1,1,3,1,2'b10,4'hC, 1,1,1,3,1));  // fire+commit same PE/warp: net 0
    tbl.push_back(mk(0,0,0,1,2'b00,4'h0, 0,1,1,3,1));
    tbl.push_back(mk(1,0,0,0,2'b00,4'h0, 1,0,1,3,1));  // switch not ready
    tbl.push_back(mk(0,0,0,1,2'b00,4'h0, 0,1,1,3,1));

    // reset held low with a request present
    reset = 1'b0; req_valid = 1'b1; req_pe = '0; req_wid = '0; disp_ready = 1'b1;
    cmt_fire = '0; cmt_wid = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst.disp_valid", 32'(disp_valid), 32'd0);
    chk("rst.req_ready",  32'(req_ready),  32'd0);
    chk("rst.perf_crd",   perf_crd_stall,  32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rel.busy",    32'(busy),       32'd0);
    chk("rel.pending", 32'(pe_pending), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i));

    // reset with ops in flight
    reset = 1'b0; req_valid = 1'b1;
    #2;
    chk("mrst.pending",    32'(pe_pending), 32'd0);
    chk("mrst.busy",       32'(busy),       32'd0);
    chk("mrst.disp_valid", 32'(disp_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0,0,0,1,2'b10,4'hC, 0,1,0,0,0), "late_cmt");
    apply(idle_rr(), "late_idle");
    chk("perf_crd.zero", perf_crd_stall, 32'd0);
    chk("perf_ord.zero", perf_ord_stall, 32'd0);

    // stall accounting: 3 credit stalls then 2 order stalls
    for (int i = 0; i < 4; i++)
      apply(mk(1,0,2'(i),1,2'b00,4'h0, 1,1,3'(i),0,(i != 0)), $sformatf("p%0d", i));
    for (int i = 0; i < 3; i++)
      apply(mk(1,0,0,1,2'b00,4'h0, 0,0,4,0,1), $sformatf("pc%0d", i));
    for (int i = 0; i < 2; i++)
      apply(mk(1,1,0,1,2'b00,4'h0, 0,0,4,0,1), $sformatf("po%0d", i));
    apply(mk(0,0,0,1,2'b00,4'h0, 0,0,4,0,1), "pend");
`ifdef PE_SCHED_PERF_EN
    chk("perf_crd", perf_crd_stall, 32'd3);
    chk("perf_ord", perf_ord_stall, 32'd2);
`else
    chk("perf_crd", perf_crd_stall, 32'd0);
    chk("perf_ord", perf_ord_stall, 32'd0);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic vec_t idle_rr();
    return mk(0, 0, 0, 1, 2'b00, 4'h0, 0, 1, 0, 0, 0);
  endfunction

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
